even_counter_pingpong_ctrl: RTL and testbench

- Upstream command sequencer for the 4-bit even up/down counter (ports clk, reset, load, count_en, c[1:0], data_in[3:0], count[3:0]).
- Drives the counter's load/count_en/c/data_in so that it sweeps ping-pong between MIN_VAL and MAX_VAL, dwelling at each end, for a programmed number of laps.
- Observes the counter's `count` output as feedback and flags completion.

---
 rtl/even_counter_pingpong_ctrl.sv | 130 +++++++++++++
 tb/tb_even_counter_pingpong_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/even_counter_pingpong_ctrl.sv
// Command sequencer for the 4-bit even up/down counter: sweeps it ping-pong
// between MIN_VAL and MAX_VAL with a dwell at each end, for LAPS laps.
module even_counter_pingpong_ctrl #(
  parameter int unsigned MAX_VAL = 14,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned DWELL   = 2,
  parameter int unsigned LAPS    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] preset,
  input  logic [3:0] count,
  output logic       load,
  output logic       count_en,
  output logic [1:0] c,
  output logic [3:0] data_in,
  output logic [3:0] lap_cnt,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] MAX4      = MAX_VAL[3:0];
  localparam logic [3:0] MIN4      = MIN_VAL[3:0];
  localparam logic [3:0] LAPS4     = LAPS[3:0];
  localparam logic [3:0] DWELL_END = 4'(DWELL - 1);

  localparam logic [1:0] C_UP   = 2'b00;
  localparam logic [1:0] C_DOWN = 2'b01;
  localparam logic [1:0] C_HOLD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_TOP,
    S_DOWN,
    S_BOT,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] dwell_cnt;
  logic [3:0] dwell_nxt;
  logic [3:0] lap_nxt;

  assign data_in = preset;

  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell_cnt;
    lap_nxt   = lap_cnt;
    if (stop && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      dwell_nxt = '0;
      lap_nxt   = '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start && !stop) begin
            state_nxt = S_LOAD;
            lap_nxt   = '0;
          end
        end
        S_LOAD: state_nxt = S_UP;
        S_UP: begin
          // count lags the command by one cycle; the counter saturates, so
          // the extra up command issued on detection cannot overshoot
          if (count >= MAX4) begin
            state_nxt = S_TOP;
            dwell_nxt = '0;
          end
        end
        S_TOP: begin
          if (dwell_cnt == DWELL_END) state_nxt = S_DOWN;
          else                        dwell_nxt = dwell_cnt + 4'd1;
        end
        S_DOWN: begin
          if (count <= MIN4) begin
            state_nxt = S_BOT;
            dwell_nxt = '0;
          end
        end
        S_BOT: begin
          if (dwell_cnt == DWELL_END) begin
            lap_nxt   = lap_cnt + 4'd1;
            state_nxt = ((lap_cnt + 4'd1) == LAPS4) ? S_DONE : S_UP;
          end else begin
            dwell_nxt = dwell_cnt + 4'd1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state
  // exactly, as if decoded from it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      dwell_cnt <= '0;
      lap_cnt   <= '0;
      load      <= 1'b0;
      count_en  <= 1'b0;
      c         <= C_HOLD;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      dwell_cnt <= dwell_nxt;
      lap_cnt   <= lap_nxt;
      load      <= (state_nxt == S_LOAD);
      count_en  <= (state_nxt == S_UP) || (state_nxt == S_TOP) ||
                   (state_nxt == S_DOWN) || (state_nxt == S_BOT);
      busy      <= (state_nxt == S_LOAD) || (state_nxt == S_UP) ||
                   (state_nxt == S_TOP) || (state_nxt == S_DOWN) ||
                   (state_nxt == S_BOT);
      done      <= (state_nxt == S_DONE);
      unique case (state_nxt)
        S_UP:    c <= C_UP;
        S_DOWN:  c <= C_DOWN;
        default: c <= C_HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_even_counter_pingpong_ctrl.sv
// Bench for even_counter_pingpong_ctrl: two configurations driven in parallel,
// each closing the loop through a behavioural even counter, checked per cycle.
module tb_even_counter_pingpong_ctrl;

  localparam int MAXV = 14;
  localparam int MINV = 0;
  localparam int DW[2] = '{2, 1};
  localparam int LP[2] = '{2, 1};

  localparam int K_IDLE = 0, K_LOAD = 1, K_UP = 2, K_TOP = 3,
                 K_DOWN = 4, K_BOT = 5, K_DONE = 6;

  typedef struct packed {
    logic [2:0] kind;
    logic       load;
    logic       en;
    logic [1:0] c;
    logic       busy;
    logic       done;
    logic [3:0] lap;
    logic [3:0] cnt;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset, start, stop;
  logic [3:0] preset;
  logic       ld[2], en[2], bsy[2], dn[2];
  logic [1:0] cc[2];
  logic [3:0] din[2], lap[2], cnt[2];

  int   checks = 0;
  int   errors = 0;
  ent_t cur[2];
  ent_t q[2][$];

  always #5 clk = ~clk;

  even_counter_pingpong_ctrl #(.MAX_VAL(14), .MIN_VAL(0), .DWELL(2), .LAPS(2)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .preset(preset),
    .count(cnt[0]), .load(ld[0]), .count_en(en[0]), .c(cc[0]), .data_in(din[0]),
    .lap_cnt(lap[0]), .busy(bsy[0]), .done(dn[0]));

  even_counter_pingpong_ctrl #(.MAX_VAL(14), .MIN_VAL(0), .DWELL(1), .LAPS(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .preset(preset),
    .count(cnt[1]), .load(ld[1]), .count_en(en[1]), .c(cc[1]), .data_in(din[1]),
    .lap_cnt(lap[1]), .busy(bsy[1]), .done(dn[1]));

  function automatic logic [3:0] ctr_next(logic l, logic e, logic [1:0] m,
                                          logic [3:0] d, logic [3:0] v);
    if (l) return d & 4'hE;
    if (!e) return v;
    if (m == 2'b00) return (v >= 4'd14) ? 4'd14 : v + 4'd2;
    if (m == 2'b01) return (v <= 4'd1) ? 4'd0 : v - 4'd2;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) cnt[i] <= 4'd0;
      else        cnt[i] <= ctr_next(ld[i], en[i], cc[i], din[i], cnt[i]);
    end
  end

  function automatic ent_t mk(int k, int lp, logic [3:0] v);
    ent_t e;
    e.kind = 3'(k);
    e.lap  = 4'(lp);
    e.cnt  = v;
    e.load = (k == K_LOAD);
    e.en   = (k >= K_UP) && (k <= K_BOT);
    e.c    = (k == K_UP) ? 2'b00 : (k == K_DOWN) ? 2'b01 : 2'b11;
    e.busy = (k >= K_LOAD) && (k <= K_BOT);
    e.done = (k == K_DONE);
    return e;
  endfunction

  function automatic logic [3:0] after(ent_t e, logic [3:0] p);
    return ctr_next(e.load, e.en, e.c, p, e.cnt);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole expected trace of one accepted start, lap by lap.
  task automatic build(input int i, input logic [3:0] p, input logic [3:0] v0);
    ent_t e;
    logic [3:0] v;
    q[i].delete();
    v = v0;
    e = mk(K_LOAD, 0, v); q[i].push_back(e); v = after(e, p);
    for (int l = 0; l < LP[i]; l++) begin
      do begin e = mk(K_UP, l, v); q[i].push_back(e); v = after(e, p); end
      while (int'(e.cnt) < MAXV);
      repeat (DW[i]) begin e = mk(K_TOP, l, v); q[i].push_back(e); v = after(e, p); end
      do begin e = mk(K_DOWN, l, v); q[i].push_back(e); v = after(e, p); end
      while (int'(e.cnt) > MINV);
      repeat (DW[i]) begin e = mk(K_BOT, l, v); q[i].push_back(e); v = after(e, p); end
    end
    q[i].push_back(mk(K_DONE, LP[i], v));
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      string n;
      n = (i == 0) ? "A" : "B";
      check({n, ".load"},     32'(ld[i]),  32'(cur[i].load));
      check({n, ".count_en"}, 32'(en[i]),  32'(cur[i].en));
      check({n, ".c"},        32'(cc[i]),  32'(cur[i].c));
      check({n, ".busy"},     32'(bsy[i]), 32'(cur[i].busy));
      check({n, ".done"},     32'(dn[i]),  32'(cur[i].done));
      check({n, ".lap_cnt"},  32'(lap[i]), 32'(cur[i].lap));
      check({n, ".data_in"},  32'(din[i]), 32'(preset));
      check({n, ".count"},    32'(cnt[i]), 32'(cur[i].cnt));
    end
  endtask

  task automatic step(input logic st, input logic sp, input logic rs, input logic [3:0] pr);
    ent_t nx[2];
    start = st; stop = sp; reset = rs; preset = pr;
    for (int i = 0; i < 2; i++) begin
      if (!rs) begin
        q[i].delete();
        nx[i] = mk(K_IDLE, 0, 4'd0);
      end else if (sp && (int'(cur[i].kind) != K_IDLE)) begin
        q[i].delete();
        nx[i] = mk(K_IDLE, 0, after(cur[i], pr));
      end else if (!cur[i].busy && st && !sp) begin
        build(i, pr, after(cur[i], pr));
        nx[i] = q[i].pop_front();
      end else if (q[i].size() > 0) begin
        nx[i] = q[i].pop_front();
      end else begin
        nx[i] = cur[i];
        nx[i].cnt = after(cur[i], pr);
      end
    end
    if (!rs) begin
      // reset is synchronous: nothing may move before the edge
      #2;
      check("A.busy_pre_edge", 32'(bsy[0]), 32'(cur[0].busy));
      check("A.lap_pre_edge",  32'(lap[0]), 32'(cur[0].lap));
      check("B.done_pre_edge", 32'(dn[1]),  32'(cur[1].done));
    end
    @(posedge clk); #1;
    cur = nx;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b1, preset);
  endtask

  task automatic run_until(input int k, input int v, input int budget);
    int found;
    found = 0;
    for (int t = 0; t < budget; t++) begin
      if (int'(cur[0].kind) == k && (v < 0 || int'(cur[0].cnt) == v)) begin
        found = 1;
        break;
      end
      step(1'b0, 1'b0, 1'b1, preset);
    end
    check("wait_state", 32'(found), 32'd1);
  endtask

  task automatic sweep(input logic [3:0] p);
    step(1'b1, 1'b0, 1'b1, p);
    run_until(K_DONE, -1, 200);
    idle(3);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; preset = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    cur[0] = mk(K_IDLE, 0, 4'd0);
    cur[1] = mk(K_IDLE, 0, 4'd0);
    check_outputs();
    idle(2);

    sweep(4'd6);
    sweep(4'd7);
    sweep(4'd15);

    step(1'b1, 1'b0, 1'b1, 4'd6);
    run_until(K_DOWN, 8, 200);
    step(1'b0, 1'b1, 1'b1, 4'd6);
    idle(3);

    step(1'b1, 1'b0, 1'b1, 4'd6);
    run_until(K_TOP, 14, 200);
    step(1'b0, 1'b0, 1'b0, 4'd6);
    idle(2);

    sweep(4'd4);
    step(1'b1, 1'b0, 1'b1, 4'd10);
    repeat (6) begin
      step(1'b1, 1'b0, 1'b1, 4'd10);
      idle(2);
    end
    run_until(K_DONE, -1, 200);
    step(1'b0, 1'b1, 1'b1, 4'd10);
    step(1'b1, 1'b1, 1'b1, 4'd10);
    idle(2);

    for (int ep = 0; ep < 40; ep++) begin
      logic [3:0] p;
      int len;
      p = 4'($urandom_range(0, 15));
      len = $urandom_range(0, 120);
      step(1'b1, 1'b0, 1'b1, p);
      for (int t = 0; t < len; t++) begin
        logic st, sp, rs;
        st = ($urandom_range(0, 7) == 0);
        sp = ($urandom_range(0, 39) == 0);
        rs = !($urandom_range(0, 59) == 0);
        step(st, sp, rs, p);
      end
      idle(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
